// File: rtl/simple_ctrl_pkg.sv
// Shared types, instruction field positions and an encoding helper for the
// simple_ctrl sequencer and anything that needs to build instruction words.
package simple_ctrl_pkg;

   localparam int INSTR_W = 16;

   localparam int CLS_HI = 15;
   localparam int CLS_LO = 14;
   localparam int OP_HI  = 13;
   localparam int OP_LO  = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 7;

   typedef enum logic [1:0] {
      CLS_ALU = 2'b00,
      CLS_LDA = 2'b01,
      CLS_JMP = 2'b10,
      CLS_HLT = 2'b11
   } class_e;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_READ_A = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Bits outside the named fields are left zero; JMP targets are OR-ed in by the caller.
   function automatic logic [INSTR_W-1:0] mk_instr(
      input class_e     cls,
      input logic [2:0] op,
      input logic [1:0] rd,
      input logic [1:0] rs
   );
      logic [INSTR_W-1:0] w;
      w                = '0;
      w[CLS_HI:CLS_LO] = cls;
      w[OP_HI:OP_LO]   = op;
      w[RD_HI:RD_LO]   = rd;
      w[RS_HI:RS_LO]   = rs;
      return w;
   endfunction

endpackage

// File: rtl/simple_pc.sv
// Program counter register: synchronous active-low reset, load beats increment,
// increment wraps modulo 2**PC_W.
module simple_pc
   import simple_ctrl_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/simple_ctrl_seq.sv
// Non-pipelined instruction sequencer: fetches from a 1-cycle ROM, decodes into IR
// and walks READ_A -> EXEC -> WB, driving the datapath strobes from state and IR.
module simple_ctrl_seq
   import simple_ctrl_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int RET_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      instruction_wire,
   input  logic             stall,
   output logic [PC_W-1:0]  pc_addr,
   output logic [2:0]       ALU_opcode_wire,
   output logic [1:0]       RF_addr,
   output logic             A_re,
   output logic             ALU_ce,
   output logic             RF_we,
   output logic             halted,
   output logic [RET_W-1:0] retired,
   output state_e           state_dbg
);

   state_e             state_q;
   state_e             state_d;
   logic [INSTR_W-1:0] ir_q;
   logic [INSTR_W-1:0] ir_d;
   logic [RET_W-1:0]   retired_q;
   logic [RET_W-1:0]   retired_d;
   logic               pc_inc;
   logic               pc_load;
   class_e             in_cls;
   class_e             ir_cls;
   logic               unused_ir_bits;

   assign in_cls         = class_e'(instruction_wire[CLS_HI:CLS_LO]);
   assign ir_cls         = class_e'(ir_q[CLS_HI:CLS_LO]);
   assign unused_ir_bits = ^ir_q[RS_LO-1:0];

   // A stalled cycle leaves every _d equal to its _q and raises no PC control.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      if (!stall) begin
         case (state_q)
            ST_FETCH: begin
               state_d = ST_DECODE;
            end
            ST_DECODE: begin
               ir_d = instruction_wire;
               case (in_cls)
                  CLS_ALU, CLS_LDA: begin
                     state_d = ST_READ_A;
                  end
                  CLS_JMP: begin
                     state_d   = ST_FETCH;
                     pc_load   = 1'b1;
                     retired_d = retired_q + RET_W'(1);
                  end
                  CLS_HLT: begin
                     state_d   = ST_HALT;
                     retired_d = retired_q + RET_W'(1);
                  end
                  default: begin
                     state_d = ST_FETCH;
                  end
               endcase
            end
            ST_READ_A: begin
               if (ir_cls == CLS_LDA) begin
                  state_d   = ST_FETCH;
                  pc_inc    = 1'b1;
                  retired_d = retired_q + RET_W'(1);
               end else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_d = ST_WB;
            end
            ST_WB: begin
               state_d   = ST_FETCH;
               pc_inc    = 1'b1;
               retired_d = retired_q + RET_W'(1);
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_FETCH;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Moore decode of state and IR; stall masks the enables but not address/opcode.
   always_comb begin
      A_re            = 1'b0;
      ALU_ce          = 1'b0;
      RF_we           = 1'b0;
      RF_addr         = '0;
      ALU_opcode_wire = '0;
      case (state_q)
         ST_READ_A: begin
            RF_addr = ir_q[RS_HI:RS_LO];
            A_re    = !stall;
         end
         ST_EXEC: begin
            ALU_opcode_wire = ir_q[OP_HI:OP_LO];
            ALU_ce          = !stall;
         end
         ST_WB: begin
            RF_addr = ir_q[RD_HI:RD_LO];
            RF_we   = !stall;
         end
         default: begin
            RF_addr = '0;
         end
      endcase
   end

   simple_pc #(
      .PC_W(PC_W)
   ) u_pc (
      .clk     (clk),
      .rst     (rst),
      .inc     (pc_inc),
      .load    (pc_load),
      .load_val(instruction_wire[PC_W-1:0]),
      .pc      (pc_addr)
   );

   assign halted    = (state_q == ST_HALT);
   assign retired   = retired_q;
   assign state_dbg = state_q;

endmodule
